image_processing_accelerator: RTL and testbench
===============================================

// Module: image_processing_accelerator
// PURPOSE
//  Streaming BMP point-operation engine between two slave input ports and one master output port.
//  It accepts a whole BMP file as little-endian DATA_WIDTH words and parses the header on the fly.
//  Header bytes pass through unmodified; pixel bytes are transformed per the selected mode.
//  The result is streamed to mstr0, and completion is flagged on mstr0_cmplt.
// PARAMETERS
//  DATA_WIDTH  32  input/output word width in bits; must be a multiple of 8.
//  COLOR_SIZE  8   colour-channel width in bits; also the width of proc_val (`COLOR_SIZE macro).
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk               in   1           system clock, rising edge
//  rst_n             in   1           asynchronous active-low reset
//  slv0_mode         in   2           slave0 op: 00 pass, 01 add, 10 subtract, 11 threshold
//  slv0_data_valid   in   1           slave0 word valid
//  slv0_proc_val     in   COLOR_SIZE  slave0 operand
//  slv0_data         in   DATA_WIDTH  slave0 file word; byte k occupies bits [8k+7:8k]
//  slv0_ready        out  1           slave0 may transfer
//  slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data, slv1_ready   same as slave0, for slave1
//  mstr0_cmplt       out  1           one-cycle pulse: file fully emitted
//  mstr0_ready       in   1           downstream accepts the output word
//  mstr0_data        out  DATA_WIDTH  processed word
//  mstr0_data_valid  out  2           00 none, 01 valid word, 10 valid last word, 11 unused
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0; state IDLE; byte counter, file_size, data_offset and owner cleared.
//  Reset mid-file aborts the file; any partially emitted output is discarded.
//  Transfer rules:
//   - Slave transfer occurs on a rising edge with data_valid & ready.
//   - Master transfer occurs with mstr0_data_valid!=0 & mstr0_ready.
//  Ownership: in IDLE the first slave to assert data_valid owns the stream until DONE; slv0 wins ties.
//   The non-owner's ready is held at 0.
//  Owner ready = state in {HDR,PIX} & (output register empty | mstr0_ready).
//  Latency: a word accepted at edge N appears on mstr0_data after edge N, i.e. 1 cycle.
//   - The output register holds while mstr0_data_valid!=0 & !mstr0_ready.
//  FSM:
//   - IDLE->HDR on ownership.
//   - HDR->PIX once byte counter >= 14 and >= data_offset.
//   - HDR/PIX->DONE when the last-word transfer to mstr0 completes.
//   - DONE->IDLE after 1 cycle; mstr0_cmplt=1 only in DONE.
//  Header capture (byte index i, 32-bit counter): file_size = bytes 2..5, data_offset = bytes 10..13, LE.
//  Per byte i of each accepted word:
//   - i < 14 or i < data_offset: pass through.
//   - otherwise pixel: f(x) applied.
//  f(x):
//   - 00: x
//   - 01: min(x+proc_val,255), saturating
//   - 10: max(x-proc_val,0), saturating
//   - 11: (x>=proc_val)?255:0
//  The owner's mode and proc_val are sampled with each accepted word.
//  Last word: the word containing byte file_size-1 is flagged 10.
//   - Its bytes with index >= file_size are output as 0.
//  Boundaries:
//   - file_size < 14 is treated as 14 (header-only, pass through).
//   - data_offset > file_size: all bytes pass through.
//   - data_valid while ready=0 is ignored; no data is lost.
//   - Simultaneous input accept and output drain in the same cycle is allowed (full throughput).
// TESTING
//  - Reset: hold rst_n=0 -> slv0_ready=0, slv1_ready=0, mstr0_data_valid=00, mstr0_cmplt=0.
//  - 62-byte BMP (size 62, offset 54) on slv0, mode 00, mstr0_ready=1 -> identical bytes out, 16 words.
//    Word 15 is flagged 10, its bytes 62-63 are 0, then mstr0_cmplt pulses.
//  - Same file, mode 01, proc_val=0x20, pixel bytes 0xF0,0x10 -> 0xFF,0x30.
//    Header bytes 0..53 unchanged.
//  - Mode 10, proc_val=0x20, pixel 0x10 -> 0x00; mode 11, proc_val=0x80, pixels 0x7F,0x80 -> 0x00,0xFF.
//  - Backpressure: mstr0_ready=0 for 5 cycles -> mstr0_data stable, slv0_ready=0; no byte lost or duplicated.
//  - slv0 and slv1 valid in the same IDLE cycle -> slv0 owns, slv1_ready=0 until cmplt.
//    rst_n pulse mid-file -> all outputs 0 at once.

Source files
------------

// File: rtl/image_processing_accelerator_if.sv
// Bundle of the accelerator's streaming signals: two input slaves and one output master.
//   slv0_* / slv1_* : mode, data_valid, proc_val, data in; ready out (from the accelerator)
//   mstr0_*         : data, data_valid[1:0], cmplt out; ready in (from downstream)
// Modport 'slave' is the accelerator's view; modport 'master' is the environment's view.
interface image_processing_accelerator_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned COLOR_SIZE = 8
) ();
    logic [1:0]            slv0_mode;
    logic                  slv0_data_valid;
    logic [COLOR_SIZE-1:0] slv0_proc_val;
    logic [DATA_WIDTH-1:0] slv0_data;
    logic                  slv0_ready;

    logic [1:0]            slv1_mode;
    logic                  slv1_data_valid;
    logic [COLOR_SIZE-1:0] slv1_proc_val;
    logic [DATA_WIDTH-1:0] slv1_data;
    logic                  slv1_ready;

    logic                  mstr0_cmplt;
    logic                  mstr0_ready;
    logic [DATA_WIDTH-1:0] mstr0_data;
    logic [1:0]            mstr0_data_valid;

    modport slave (
        input  slv0_mode, slv0_data_valid, slv0_proc_val, slv0_data,
        output slv0_ready,
        input  slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data,
        output slv1_ready,
        output mstr0_cmplt, mstr0_data, mstr0_data_valid,
        input  mstr0_ready
    );

    modport master (
        output slv0_mode, slv0_data_valid, slv0_proc_val, slv0_data,
        input  slv0_ready,
        output slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data,
        input  slv1_ready,
        input  mstr0_cmplt, mstr0_data, mstr0_data_valid,
        output mstr0_ready
    );
endinterface

// File: rtl/image_processing_accelerator.sv
// Streaming BMP point-operation engine. A whole BMP file arrives as little-endian words on
// whichever slave claims the stream first; header bytes pass through, pixel bytes get a
// point operation (pass / saturating add / saturating subtract / threshold), and the result
// leaves on mstr0 with one cycle of latency. mstr0_cmplt pulses once the last word has left.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport carrying slv0_*, slv1_* and mstr0_* signals
module image_processing_accelerator #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned COLOR_SIZE = 8
) (
    input logic                          clk,
    input logic                          rst_n,
    image_processing_accelerator_if.slave bus
);
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned OpW      = COLOR_SIZE + 9;
    localparam logic [OpW-1:0] ByteMax = OpW'(255);

    typedef enum logic [1:0] {StIdle, StHdr, StPix, StDone} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;       // 0: slv0, 1: slv1
    logic [31:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]           file_size_q, file_size_d;
    logic [31:0]           data_offset_q, data_offset_d;
    logic                  last_acc_q, last_acc_d; // last word taken, stop accepting
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]            out_valid_q, out_valid_d;

    logic                  own_valid;
    logic [1:0]            own_mode;
    logic [COLOR_SIZE-1:0] own_pv;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  can_accept, accept;

    logic [31:0]           idx;
    logic [1:0]            sel;
    logic [31:0]           fs_m, off_m, eff_size;
    logic                  is_last;
    logic [DATA_WIDTH-1:0] proc_data;

    function automatic logic [7:0] point_op(input logic [1:0] mode, input logic [7:0] x,
                                            input logic [COLOR_SIZE-1:0] pv);
        logic [OpW-1:0] xe, pe, r;
        xe = OpW'(x);
        pe = OpW'(pv);
        r  = xe;
        unique case (mode)
            2'b00: r = xe;
            2'b01: begin
                r = xe + pe;
                if (r > ByteMax) r = ByteMax;
            end
            2'b10: r = (xe >= pe) ? xe - pe : '0;
            2'b11: r = (xe >= pe) ? ByteMax : '0;
            default: r = xe;
        endcase
        return r[7:0];
    endfunction

    // Owner mux; the non-owner is simply never looked at.
    assign own_valid = owner_q ? bus.slv1_data_valid : bus.slv0_data_valid;
    assign own_mode  = owner_q ? bus.slv1_mode       : bus.slv0_mode;
    assign own_pv    = owner_q ? bus.slv1_proc_val   : bus.slv0_proc_val;
    assign own_data  = owner_q ? bus.slv1_data       : bus.slv0_data;

    assign can_accept = ((state_q == StHdr) || (state_q == StPix)) && !last_acc_q &&
                        ((out_valid_q == 2'b00) || bus.mstr0_ready);
    assign accept     = can_accept && own_valid;

    assign bus.slv0_ready       = can_accept && !owner_q;
    assign bus.slv1_ready       = can_accept && owner_q;
    assign bus.mstr0_data       = out_data_q;
    assign bus.mstr0_data_valid = out_valid_q;
    assign bus.mstr0_cmplt      = (state_q == StDone);

    // Header fields can straddle the incoming word, so merge this word's header bytes into
    // the captured values before classifying its own bytes. Offsets 2..5 and 10..13 both map
    // to field byte (idx - 2) mod 4.
    always_comb begin
        idx       = '0;
        sel       = '0;
        fs_m      = file_size_q;
        off_m     = data_offset_q;
        proc_data = '0;
        for (int k = 0; k < NumBytes; k++) begin
            idx = byte_cnt_q + 32'(k);
            sel = idx[1:0] - 2'd2;
            if (idx >= 32'd2 && idx <= 32'd5) begin
                fs_m[{sel, 3'b000} +: 8] = own_data[8*k +: 8];
            end else if (idx >= 32'd10 && idx <= 32'd13) begin
                off_m[{sel, 3'b000} +: 8] = own_data[8*k +: 8];
            end
        end
        eff_size = (fs_m < 32'd14) ? 32'd14 : fs_m;
        is_last  = (eff_size <= byte_cnt_q + NumBytes);
        for (int k = 0; k < NumBytes; k++) begin
            idx = byte_cnt_q + 32'(k);
            if (idx >= eff_size) begin
                proc_data[8*k +: 8] = 8'h00;
            end else if (idx >= 32'd14 && idx >= off_m) begin
                proc_data[8*k +: 8] = point_op(own_mode, own_data[8*k +: 8], own_pv);
            end else begin
                proc_data[8*k +: 8] = own_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        byte_cnt_d    = byte_cnt_q;
        file_size_d   = file_size_q;
        data_offset_d = data_offset_q;
        last_acc_d    = last_acc_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;

        if (accept) begin
            out_data_d    = proc_data;
            out_valid_d   = is_last ? 2'b10 : 2'b01;
            byte_cnt_d    = byte_cnt_q + NumBytes;
            file_size_d   = fs_m;
            data_offset_d = off_m;
            last_acc_d    = is_last;
        end else if (bus.mstr0_ready) begin
            out_valid_d = 2'b00;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.slv0_data_valid) begin
                    owner_d = 1'b0;
                    state_d = StHdr;
                end else if (bus.slv1_data_valid) begin
                    owner_d = 1'b1;
                    state_d = StHdr;
                end
            end
            StHdr, StPix: begin
                if (out_valid_q == 2'b10 && bus.mstr0_ready) begin
                    state_d = StDone;
                end else if (state_q == StHdr && byte_cnt_q >= 32'd14 &&
                             byte_cnt_q >= data_offset_q) begin
                    state_d = StPix;
                end
            end
            StDone: begin
                state_d       = StIdle;
                byte_cnt_d    = '0;
                file_size_d   = '0;
                data_offset_d = '0;
                last_acc_d    = 1'b0;
                owner_d       = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            byte_cnt_q    <= '0;
            file_size_q   <= '0;
            data_offset_q <= '0;
            last_acc_q    <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 2'b00;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            byte_cnt_q    <= byte_cnt_d;
            file_size_q   <= file_size_d;
            data_offset_q <= data_offset_d;
            last_acc_q    <= last_acc_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_image_processing_accelerator.sv
// Self-checking bench: a 62-byte BMP (offset 54) is streamed in several modes; expected output
// words are queued as each word is issued and a monitor pops them as mstr0 transfers occur.
module tb_image_processing_accelerator;
    localparam int unsigned DW = 32;
    localparam int unsigned CS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_processing_accelerator_if #(.DATA_WIDTH(DW), .COLOR_SIZE(CS)) bus ();

    image_processing_accelerator #(.DATA_WIDTH(DW), .COLOR_SIZE(CS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [33:0] sb_q[$];
    bit          cmplt_pending = 0;
    int          cmplt_count = 0;
    bit          abort = 0;
    bit          watch_slv1 = 0;
    int          slv1_bad = 0;

    logic [7:0] file_bytes [0:61];
    // Pixel bytes 54..61 and their hand-computed results per mode
    // (mode 01/10 with proc_val 0x20, mode 11 with proc_val 0x80).
    logic [7:0] pix_in [0:7] = '{8'hF0, 8'h10, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h20, 8'h1F};
    logic [7:0] exp_pix [0:3][0:7] = '{
        '{8'hF0, 8'h10, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h20, 8'h1F},
        '{8'hFF, 8'h30, 8'h9F, 8'hA0, 8'h20, 8'hFF, 8'h40, 8'h3F},
        '{8'hD0, 8'h00, 8'h5F, 8'h60, 8'h00, 8'hDF, 8'h00, 8'h00},
        '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00}
    };

    function automatic logic [7:0] exp_byte(input int tbl, input int i);
        if (i >= 62) return 8'h00;
        if (i < 54) return file_bytes[i];
        return exp_pix[tbl][i-54];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmplt_pending) begin
                    check("cmplt_pulse", 64'(bus.mstr0_cmplt), 64'd1);
                    cmplt_count++;
                    cmplt_pending = 0;
                end else if (bus.mstr0_cmplt) begin
                    check("cmplt_spurious", 64'(bus.mstr0_cmplt), 64'd0);
                end
                if (watch_slv1 && bus.slv1_ready) slv1_bad++;
                if (bus.mstr0_data_valid != 2'b00 && bus.mstr0_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_word", 64'({bus.mstr0_data_valid, bus.mstr0_data}),
                              64'h3_FFFF_FFFF_FFFF);
                    end else begin
                        exp = sb_q.pop_front();
                        check("out_word", 64'({bus.mstr0_data_valid, bus.mstr0_data}), 64'(exp));
                        if (exp[33:32] == 2'b10) cmplt_pending = 1;
                    end
                end
            end
        end
    end

    task automatic drive_word(input bit port, input logic [1:0] mode, input logic [7:0] pv,
                              input logic [31:0] data, input logic [33:0] exp);
        int waited;
        bit rdy;
        waited = 0;
        if (!port) begin
            bus.slv0_mode = mode; bus.slv0_proc_val = pv; bus.slv0_data = data;
            bus.slv0_data_valid = 1'b1;
        end else begin
            bus.slv1_mode = mode; bus.slv1_proc_val = pv; bus.slv1_data = data;
            bus.slv1_data_valid = 1'b1;
        end
        sb_q.push_back(exp);
        forever begin
            @(negedge clk);
            rdy = port ? bus.slv1_ready : bus.slv0_ready;
            if (abort || rdy) break;
            waited++;
            if (waited > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got ready 0 for %0d cycles want 1", waited);
                abort = 1;
                break;
            end
        end
        if (!abort) begin
            @(posedge clk); #1;
        end
        if (!port) bus.slv0_data_valid = 1'b0;
        else       bus.slv1_data_valid = 1'b0;
    endtask

    task automatic send_file(input bit port, input logic [1:0] mode, input logic [7:0] pv,
                             input int tbl);
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d, e;
            for (int k = 0; k < 4; k++) begin
                d[8*k +: 8] = (4*w + k < 62) ? file_bytes[4*w + k] : 8'hAA;
                e[8*k +: 8] = exp_byte(tbl, 4*w + k);
            end
            drive_word(port, mode, pv, d, {(w == 15) ? 2'b10 : 2'b01, e});
            if (abort) return;
        end
    endtask

    task automatic wait_cmplt(input int c0);
        int waited;
        waited = 0;
        while (cmplt_count <= c0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (cmplt_count <= c0) begin
            checks++; errors++;
            $display("FAIL cmplt_timeout: got no cmplt pulse want one within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [31:0] held;

        for (int i = 0; i < 62; i++) file_bytes[i] = 8'(i * 7 + 3);
        file_bytes[0] = 8'h42; file_bytes[1] = 8'h4D;
        {file_bytes[5], file_bytes[4], file_bytes[3], file_bytes[2]} = 32'd62;
        for (int i = 6; i < 10; i++) file_bytes[i] = 8'h00;
        {file_bytes[13], file_bytes[12], file_bytes[11], file_bytes[10]} = 32'd54;
        for (int i = 0; i < 8; i++) file_bytes[54 + i] = pix_in[i];

        bus.slv0_mode = 2'b00; bus.slv0_data_valid = 1'b0; bus.slv0_proc_val = '0;
        bus.slv0_data = '0;
        bus.slv1_mode = 2'b00; bus.slv1_data_valid = 1'b0; bus.slv1_proc_val = '0;
        bus.slv1_data = '0;
        bus.mstr0_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_slv0_ready", 64'(bus.slv0_ready), 64'd0);
        check("rst_slv1_ready", 64'(bus.slv1_ready), 64'd0);
        check("rst_mstr0_valid", 64'(bus.mstr0_data_valid), 64'd0);
        check("rst_mstr0_cmplt", 64'(bus.mstr0_cmplt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Each mode on slv0 with free-flowing output
        c0 = cmplt_count; send_file(0, 2'b00, 8'h00, 0); wait_cmplt(c0);
        c0 = cmplt_count; send_file(0, 2'b01, 8'h20, 1); wait_cmplt(c0);
        c0 = cmplt_count; send_file(0, 2'b10, 8'h20, 2); wait_cmplt(c0);

        // Backpressure during a threshold file
        c0 = cmplt_count;
        fork
            send_file(0, 2'b11, 8'h80, 3);
            begin
                repeat (6) @(posedge clk);
                #1 bus.mstr0_ready = 1'b0;
                @(negedge clk);
                held = bus.mstr0_data;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_data_stable", 64'(bus.mstr0_data), 64'(held));
                    check("bp_slv0_ready", 64'(bus.slv0_ready), 64'd0);
                    check("bp_valid_held", 64'(bus.mstr0_data_valid != 2'b00), 64'd1);
                end
                @(posedge clk); #1 bus.mstr0_ready = 1'b1;
            end
        join
        wait_cmplt(c0);

        // Tie in IDLE: slv0 wins, slv1 stays blocked until completion
        c0 = cmplt_count;
        bus.slv1_data = 32'hDEADBEEF; bus.slv1_mode = 2'b11; bus.slv1_proc_val = 8'h01;
        bus.slv1_data_valid = 1'b1;
        watch_slv1 = 1;
        send_file(0, 2'b01, 8'h20, 1);
        bus.slv1_data_valid = 1'b0;
        wait_cmplt(c0);
        watch_slv1 = 0;
        check("tie_slv1_blocked", 64'(slv1_bad), 64'd0);

        // Reset mid-file
        fork
            send_file(0, 2'b00, 8'h00, 0);
            begin
                repeat (6) @(posedge clk);
                #2 rst_n = 1'b0;
                abort = 1;
                #1;
                check("midrst_slv0_ready", 64'(bus.slv0_ready), 64'd0);
                check("midrst_valid", 64'(bus.mstr0_data_valid), 64'd0);
                check("midrst_data", 64'(bus.mstr0_data), 64'd0);
                check("midrst_cmplt", 64'(bus.mstr0_cmplt), 64'd0);
            end
        join
        sb_q.delete();
        cmplt_pending = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 0;
        @(posedge clk); #1;

        // Recovery after reset, on slv1
        c0 = cmplt_count; send_file(1, 2'b10, 8'h20, 2); wait_cmplt(c0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
